// File: rtl/wired_rob_ring_if.sv
// ---------------------------------------------------------------------------
// wired_rob_ring_if
//
// Bundles every non-clock, non-reset signal of the Wired reorder buffer.
//   master : the pipeline side (dispatch, CDB, operand read, commit retire)
//   slave  : the reorder buffer itself
//
// Signal groups:
//   flush_i                                   discard all entries
//   disp_valid_i / disp_info_i                dispatch request + static info
//   disp_ready_o / disp_id_o                  room for a full dispatch group, ids
//   cdb_valid_i / cdb_id_i / cdb_data_i /
//   cdb_excp_i                                completion channels
//   rd_id_i / rd_done_o / rd_data_o           renamed-operand reads
//   cm_valid_o / cm_info_o / cm_data_o /
//   cm_excp_o                                 in-order commit window
//   retire_i                                  retire a prefix of the window
//   count_o                                   occupancy
// ---------------------------------------------------------------------------
interface wired_rob_ring_if #(
    parameter int DEPTH_LOG2 = 5,
    parameter int DISPATCH_W = 2,
    parameter int CDB_W      = 2,
    parameter int COMMIT_W   = 2,
    parameter int RD_PORTS   = 4,
    parameter int DATA_W     = 32,
    parameter int INFO_W     = 64
);
    logic                                   flush_i;

    logic [DISPATCH_W-1:0]                  disp_valid_i;
    logic [DISPATCH_W-1:0][INFO_W-1:0]      disp_info_i;
    logic                                   disp_ready_o;
    logic [DISPATCH_W-1:0][DEPTH_LOG2-1:0]  disp_id_o;

    logic [CDB_W-1:0]                       cdb_valid_i;
    logic [CDB_W-1:0][DEPTH_LOG2-1:0]       cdb_id_i;
    logic [CDB_W-1:0][DATA_W-1:0]           cdb_data_i;
    logic [CDB_W-1:0]                       cdb_excp_i;

    logic [RD_PORTS-1:0][DEPTH_LOG2-1:0]    rd_id_i;
    logic [RD_PORTS-1:0]                    rd_done_o;
    logic [RD_PORTS-1:0][DATA_W-1:0]        rd_data_o;

    logic [COMMIT_W-1:0]                    cm_valid_o;
    logic [COMMIT_W-1:0][INFO_W-1:0]        cm_info_o;
    logic [COMMIT_W-1:0][DATA_W-1:0]        cm_data_o;
    logic [COMMIT_W-1:0]                    cm_excp_o;
    logic [COMMIT_W-1:0]                    retire_i;

    logic [DEPTH_LOG2:0]                    count_o;

    modport master (
        output flush_i, disp_valid_i, disp_info_i,
        output cdb_valid_i, cdb_id_i, cdb_data_i, cdb_excp_i,
        output rd_id_i, retire_i,
        input  disp_ready_o, disp_id_o, rd_done_o, rd_data_o,
        input  cm_valid_o, cm_info_o, cm_data_o, cm_excp_o, count_o
    );

    modport slave (
        input  flush_i, disp_valid_i, disp_info_i,
        input  cdb_valid_i, cdb_id_i, cdb_data_i, cdb_excp_i,
        input  rd_id_i, retire_i,
        output disp_ready_o, disp_id_o, rd_done_o, rd_data_o,
        output cm_valid_o, cm_info_o, cm_data_o, cm_excp_o, count_o
    );
endinterface

// File: rtl/wired_rob_ring.sv
// ---------------------------------------------------------------------------
// wired_rob_ring
//
// Circular reorder buffer between dispatch (P stage) and commit (C stage).
// Allocates ids at the tail, records completions from CDB_W result channels,
// serves RD_PORTS operand reads and shows an in-order window of COMMIT_W
// entries starting at the head. Flush empties the ring in one cycle.
//
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   rob    wired_rob_ring_if.slave (dispatch, CDB, read, commit, count)
//
// Optional build macro:
//   WIRED_ROB_CDB_BYPASS_EN  forward same-cycle CDB writes onto the read
//                            ports and the commit window. Undefined: all
//                            outputs come from storage (visible one cycle
//                            after the CDB write).
// ---------------------------------------------------------------------------
module wired_rob_ring #(
    parameter int DEPTH_LOG2 = 5,
    parameter int DISPATCH_W = 2,
    parameter int CDB_W      = 2,
    parameter int COMMIT_W   = 2,
    parameter int RD_PORTS   = 4,
    parameter int DATA_W     = 32,
    parameter int INFO_W     = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    wired_rob_ring_if.slave rob
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Architectural state
    ptr_t               head_q, head_d;
    ptr_t               tail_q, tail_d;
    cnt_t               count_q, count_d;
    logic [DEPTH-1:0]   done_q, done_d;
    logic [DEPTH-1:0]   excp_q, excp_d;
    logic [INFO_W-1:0]  info_ram [DEPTH];
    logic [DATA_W-1:0]  data_ram [DEPTH];

    // Derived control
    logic                       disp_ready;
    logic                       disp_fire;
    cnt_t                       disp_n;
    cnt_t                       ret_n;
    ptr_t [DISPATCH_W-1:0]      disp_id;
    ptr_t [COMMIT_W-1:0]        cm_idx;

    // Commit window / read port views (storage, optionally with bypass)
    logic [COMMIT_W-1:0]                slot_done;
    logic [COMMIT_W-1:0]                slot_excp;
    logic [COMMIT_W-1:0][DATA_W-1:0]    slot_data;
    logic [COMMIT_W-1:0][INFO_W-1:0]    slot_info;
    logic [COMMIT_W-1:0]                cm_valid;
    logic                               cm_chain;
    logic [RD_PORTS-1:0]                rd_done;
    logic [RD_PORTS-1:0][DATA_W-1:0]    rd_data;

    // Ready looks only at the registered count, so a retire in the same
    // cycle never turns a stalled dispatch into an accepted one.
    assign disp_ready = (count_q <= cnt_t'(DEPTH - DISPATCH_W));
    assign disp_fire  = disp_ready & rob.disp_valid_i[0];
    assign disp_n     = cnt_t'($countones(rob.disp_valid_i));
    assign ret_n      = cnt_t'($countones(rob.retire_i));

    always_comb begin
        for (int k = 0; k < DISPATCH_W; k++) begin
            disp_id[k] = tail_q + ptr_t'(k);
        end
    end

    always_comb begin
        for (int k = 0; k < COMMIT_W; k++) begin
            cm_idx[k] = head_q + ptr_t'(k);
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // this block leaves one unassigned, which would infer a latch.
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        done_d  = done_q;
        excp_d  = excp_q;

        if (disp_fire) begin
            for (int k = 0; k < DISPATCH_W; k++) begin
                if (rob.disp_valid_i[k]) begin
                    done_d[disp_id[k]] = 1'b0;
                    excp_d[disp_id[k]] = 1'b0;
                end
            end
            tail_d = tail_q + ptr_t'(disp_n);
        end

        // Ascending channel order: the highest channel hitting an id wins.
        for (int c = 0; c < CDB_W; c++) begin
            if (rob.cdb_valid_i[c]) begin
                done_d[rob.cdb_id_i[c]] = 1'b1;
                excp_d[rob.cdb_id_i[c]] = rob.cdb_excp_i[c];
            end
        end

        head_d  = head_q + ptr_t'(ret_n);
        count_d = count_q + (disp_fire ? disp_n : '0) - ret_n;

        if (rob.flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            done_d  = '0;
            excp_d  = '0;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            done_q  <= '0;
            excp_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            done_q  <= done_d;
            excp_q  <= excp_d;
        end
    end

    // NOTE: the RAMs carry no reset; an entry is only ever read after the
    // done bit (which is reset) says it holds meaningful content.
    always_ff @(posedge clk) begin
        if (disp_fire) begin
            for (int k = 0; k < DISPATCH_W; k++) begin
                if (rob.disp_valid_i[k]) begin
                    info_ram[disp_id[k]] <= rob.disp_info_i[k];
                end
            end
        end
        for (int c = 0; c < CDB_W; c++) begin
            if (rob.cdb_valid_i[c]) begin
                data_ram[rob.cdb_id_i[c]] <= rob.cdb_data_i[c];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Commit window view
    // -----------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < COMMIT_W; k++) begin
            slot_done[k] = done_q[cm_idx[k]];
            slot_excp[k] = excp_q[cm_idx[k]];
            slot_data[k] = data_ram[cm_idx[k]];
            slot_info[k] = info_ram[cm_idx[k]];
`ifdef WIRED_ROB_CDB_BYPASS_EN
            for (int c = 0; c < CDB_W; c++) begin
                if (rob.cdb_valid_i[c] && (rob.cdb_id_i[c] == cm_idx[k])) begin
                    slot_done[k] = 1'b1;
                    slot_excp[k] = rob.cdb_excp_i[c];
                    slot_data[k] = rob.cdb_data_i[c];
                end
            end
`endif
        end
    end

    // A slot is visible when it is occupied, done, every older slot is
    // visible, and no older visible slot carries an exception.
    always_comb begin
        cm_chain = 1'b1;
        for (int k = 0; k < COMMIT_W; k++) begin
            cm_valid[k] = cm_chain & (count_q > cnt_t'(k)) & slot_done[k];
            cm_chain    = cm_valid[k] & ~slot_excp[k];
        end
    end

    // -----------------------------------------------------------------------
    // Operand read ports
    // -----------------------------------------------------------------------
    always_comb begin
        for (int p = 0; p < RD_PORTS; p++) begin
            rd_done[p] = done_q[rob.rd_id_i[p]];
            rd_data[p] = data_ram[rob.rd_id_i[p]];
`ifdef WIRED_ROB_CDB_BYPASS_EN
            for (int c = 0; c < CDB_W; c++) begin
                if (rob.cdb_valid_i[c] && (rob.cdb_id_i[c] == rob.rd_id_i[p])) begin
                    rd_done[p] = 1'b1;
                    rd_data[p] = rob.cdb_data_i[c];
                end
            end
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign rob.disp_ready_o = disp_ready;
    assign rob.disp_id_o    = disp_id;
    assign rob.count_o      = count_q;
    assign rob.cm_valid_o   = cm_valid;
    assign rob.cm_excp_o    = slot_excp;
    assign rob.cm_data_o    = slot_data;
    assign rob.cm_info_o    = slot_info;
    assign rob.rd_done_o    = rd_done;
    assign rob.rd_data_o    = rd_data;

endmodule

// File: doc/wired_rob_ring.md
# wired_rob_ring

Parametrised reorder buffer for the Wired backend. It manages its own head/tail allocation, and both dispatch and commit widths are configurable. It sits between dispatch (P stage) and commit (C stage). It allocates ROB ids to dispatched instructions and records their completion and results from N CDB channels. It serves renamed-operand reads and presents an in-order window of up to COMMIT_W entries to commit. Flush, occupancy tracking, back-pressure and exception-blocked retire are internal to the block; they are not left to the consumer.

## Interface
Parameters:
- DEPTH_LOG2, 5: log2 of entry count; DEPTH = 1<<DEPTH_LOG2.
- DISPATCH_W, 2: dispatch lanes per cycle.
- CDB_W, 2: CDB write channels.
- COMMIT_W, 2: commit window width.
- RD_PORTS, 4: operand read ports.
- DATA_W, 32: result width.
- INFO_W, 64: opaque static-info width (pc, decode, predict, static excp).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- flush_i  in  1  discard all entries.
- disp_valid_i  in  DISPATCH_W  per-lane dispatch request; lanes must be a contiguous prefix from lane 0.
- disp_info_i  in  DISPATCH_W×INFO_W  static info per lane.
- disp_ready_o  out  1  high when free entries ≥ DISPATCH_W.
- disp_id_o  out  DISPATCH_W×DEPTH_LOG2  ids assigned this cycle; lane k = tail+k mod DEPTH.
- cdb_valid_i  in  CDB_W  completion strobe.
- cdb_id_i  in  CDB_W×DEPTH_LOG2  target id.
- cdb_data_i  in  CDB_W×DATA_W  result.
- cdb_excp_i  in  CDB_W  dynamic exception flag.
- rd_id_i  in  RD_PORTS×DEPTH_LOG2  operand ids.
- rd_done_o  out  RD_PORTS  entry completed.
- rd_data_o  out  RD_PORTS×DATA_W  entry result.
- cm_valid_o  out  COMMIT_W  window slot k is occupied and done.
- cm_info_o  out  COMMIT_W×INFO_W  static info at head+k.
- cm_data_o  out  COMMIT_W×DATA_W  result at head+k.
- cm_excp_o  out  COMMIT_W  dynamic exception at head+k.
- retire_i  in  COMMIT_W  retire slot k; must be a contiguous prefix.
- count_o  out  DEPTH_LOG2+1  occupancy.

## Operation
- State:
  - head and tail pointers, each DEPTH_LOG2 bits, wrapping modulo DEPTH.
  - count register, DEPTH_LOG2+1 bits, range 0..DEPTH.
  - done and excp bit vectors, DEPTH bits each.
  - info RAM and data RAM.
- Dispatch fire = disp_ready_o & disp_valid_i[0].
  - On fire, each valid lane k writes info to tail+k and clears done/excp at that entry.
  - tail advances by popcount(disp_valid_i).
  - disp_valid_i while disp_ready_o is low is ignored; no state change.
- CDB:
  - Each valid channel sets done, writes data and writes excp at cdb_id_i.
  - If two channels target the same id, the higher channel index wins.
  - A CDB write to an unoccupied id is illegal; the bench asserts it never happens.
- Commit window:
  - cm_valid_o[k] = (count > k) & done[head+k] & cm_valid_o[k-1].
  - If cm_excp_o[j] is set, cm_valid_o[k] is forced low for all k>j, so the exception is the last visible slot.
- Retire:
  - retire_i[k] is legal only when cm_valid_o[k] is high.
  - head advances by popcount(retire_i).
  - count updates as count + dispatched − retired, all in one cycle.
- Flush (priority over dispatch, CDB and retire in the same cycle):
  - head, tail and count reset to 0.
  - done and excp cleared.
- Ready does not credit same-cycle retire: disp_ready_o = (DEPTH − count) ≥ DISPATCH_W, computed from registered count only.

## Timing
- Reset values:
  - head, tail and count are 0.
  - done and excp bits are 0.
  - cm_valid_o = 0, rd_done_o = 0, disp_ready_o = 1, disp_id_o = 0..DISPATCH_W−1.
  - RAM contents are undefined.
- Dispatch in cycle t makes the entry countable in commit from t+1; it appears in cm_valid_o only once done.
- CDB write at t:
  - done/data visible on rd_* and cm_* at t+1 without bypass.
  - See Configuration for the bypass variant.
- Retire at t: head moves at the t edge, and the window shows the new head at t+1.
- Flush at t: at t+1, count = 0, cm_valid_o = 0 and disp_ready_o = 1.
- Wrap-around: ids and window indices are computed modulo DEPTH; a window straddling index DEPTH−1→0 is legal.
- Full: count = DEPTH is reachable only via dispatch of exactly the remaining free entries.

## Configuration
- WIRED_ROB_CDB_BYPASS_EN defined:
  - rd_done_o/rd_data_o forward same-cycle CDB writes whose cdb_id_i matches rd_id_i. The highest matching channel wins.
  - cm_valid_o/cm_data_o/cm_excp_o also forward same-cycle CDB writes, so commit sees completion at t.
- Undefined: no forwarding; all outputs come from storage only, with one-cycle visibility.

## Test plan
- Reset, then dispatch 2 lanes ×3 cycles: disp_id_o = {0,1},{2,3},{4,5}; count_o = 6; cm_valid_o = 0.
- CDB writes id 0 data 0xA5 and id 1 data 0x5A at t: at t+1, cm_valid_o = 2'b11 and cm_data_o = {0x5A,0xA5}; retire 2'b11 leaves count_o = 4.
- Fill to 32 entries: disp_ready_o low at count 31, since 1 free entry < 2 lanes; dispatch attempts ignored. Complete and retire ids 0–1, then dispatch again: new ids are 0,1 (wrap).
- Complete ids 2 and 3 with cdb_excp_i set on id 2: cm_valid_o = 2'b01 and cm_excp_o[0] = 1; slot 1 stays masked until retire.
- Flush together with dispatch, CDB and retire in the same cycle: next cycle count_o = 0, cm_valid_o = 0, disp_id_o = {0,1}.
- With WIRED_ROB_CDB_BYPASS_EN: a CDB write of id 4 data 0x1234 with rd_id_i[0] = 4 in the same cycle gives rd_done_o[0] = 1 and rd_data_o[0] = 0x1234 combinationally. Without the macro, both appear at t+1.
